// File: rtl/vc32_fetch_pkg.sv
// Shared types and helpers for the instruction fetch/prefetch stage.
package vc32_fetch_pkg;

  typedef enum logic [1:0] {IDLE, DEMAND, RESP, PREFETCH} fetch_state_t;

  function automatic int line_off_bits(input int rv);
    return $clog2(rv / 8);
  endfunction

endpackage

// File: rtl/fetch_line_buf.sv
// Two-entry line buffer (CUR + sequential NXT) with tag compare, promote and fill.
module fetch_line_buf
  import vc32_fetch_pkg::*;
#(
  parameter int RV = 32,
  parameter int TW = 30
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [TW-1:0] lookup_tag,
  input  logic          flush,
  input  logic          promote,
  input  logic          fill_cur,
  input  logic          fill_nxt,
  input  logic [TW-1:0] fill_tag,
  input  logic [RV-1:0] fill_data,
  output logic          hit_cur,
  output logic          hit_nxt,
  output logic [TW-1:0] cur_tag,
  output logic [RV-1:0] cur_data,
  output logic          nxt_valid
);

  logic          cur_valid;
  logic [TW-1:0] nxt_tag;
  logic [RV-1:0] nxt_data;

  assign hit_cur = cur_valid && (cur_tag == lookup_tag);
  assign hit_nxt = nxt_valid && (nxt_tag == lookup_tag);

  // flush outranks every write so a stale fill can never revive a line
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cur_valid <= 1'b0;
      nxt_valid <= 1'b0;
      cur_tag   <= '0;
      nxt_tag   <= '0;
      cur_data  <= '0;
      nxt_data  <= '0;
    end else if (flush) begin
      cur_valid <= 1'b0;
      nxt_valid <= 1'b0;
    end else if (fill_cur) begin
      cur_valid <= 1'b1;
      cur_tag   <= fill_tag;
      cur_data  <= fill_data;
      nxt_valid <= 1'b0;
    end else if (promote) begin
      cur_valid <= nxt_valid;
      cur_tag   <= nxt_tag;
      cur_data  <= nxt_data;
      nxt_valid <= 1'b0;
    end else if (fill_nxt) begin
      nxt_valid <= 1'b1;
      nxt_tag   <= fill_tag;
      nxt_data  <= fill_data;
    end
  end

endmodule

// File: rtl/fetch_prefetch.sv
// Fetch stage: serves execute's parcel requests from a two-line buffer and
// prefetches the next sequential line over a req/ack memory port.
//
// state    | meaning
// IDLE     | waiting for a new ifetch; lookup against CUR/NXT
// DEMAND   | miss: reading the requested line into CUR
// RESP     | idone cycle; decide whether NXT needs a prefetch
// PREFETCH | reading CUR+1 into NXT
module fetch_prefetch
  import vc32_fetch_pkg::*;
#(
  parameter int RV = 32,
  parameter int VA = RV
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [VA-1:1]     pc,
  input  logic              ifetch,
  input  logic              i_flush,
  output logic [15:0]       ins,
  output logic              iready,
  output logic              idone,
  output logic              mem_req,
  output logic [VA-1:line_off_bits(RV)] mem_addr,
  input  logic              mem_ack,
  input  logic [RV-1:0]     mem_rdata
);

  localparam int LB = line_off_bits(RV);
  localparam int TW = VA - LB;
  localparam int PW = (LB > 1) ? LB - 1 : 1;

  fetch_state_t  state;
  logic [TW-1:0] pc_tag;
  logic [TW-1:0] cur_tag;
  logic [RV-1:0] cur_data;
  logic [PW-1:0] psel;
  logic          hit_cur, hit_nxt, nxt_valid;
  logic          ifetch_q, flush_pend;
  logic          req_new, discard, promote, fill_cur, fill_nxt;

  generate
    if (LB > 1) begin : g_psel
      assign psel = pc[LB-1:1];
    end else begin : g_psel0
      assign psel = '0;
    end
  endgenerate

  assign pc_tag   = pc[VA-1:LB];
  // a fresh rising ifetch is a new request even while the old parcel is still shown
  assign req_new  = ifetch && (!iready || !ifetch_q);
  assign discard  = flush_pend || i_flush;
  assign promote  = (state == IDLE) && req_new && !i_flush && !hit_cur && hit_nxt;
  assign fill_cur = (state == DEMAND) && mem_ack && !discard;
  assign fill_nxt = (state == PREFETCH) && mem_ack && !discard;

  fetch_line_buf #(.RV(RV), .TW(TW)) u_lines (
    .clk       (clk),
    .reset     (reset),
    .lookup_tag(pc_tag),
    .flush     (i_flush),
    .promote   (promote),
    .fill_cur  (fill_cur),
    .fill_nxt  (fill_nxt),
    .fill_tag  (mem_addr),
    .fill_data (mem_rdata),
    .hit_cur   (hit_cur),
    .hit_nxt   (hit_nxt),
    .cur_tag   (cur_tag),
    .cur_data  (cur_data),
    .nxt_valid (nxt_valid)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      ins        <= '0;
      iready     <= 1'b0;
      idone      <= 1'b0;
      mem_req    <= 1'b0;
      mem_addr   <= '0;
      ifetch_q   <= 1'b0;
      flush_pend <= 1'b0;
    end else begin
      ifetch_q <= ifetch;
      idone    <= 1'b0;
      if (ifetch && !ifetch_q)
        iready <= 1'b0;
      if (mem_ack)
        flush_pend <= 1'b0;
      else if (mem_req && i_flush)
        flush_pend <= 1'b1;

      case (state)
        IDLE: begin
          if (req_new) begin
            if (!i_flush && (hit_cur || hit_nxt)) begin
              state <= RESP;
            end else begin
              state    <= DEMAND;
              mem_req  <= 1'b1;
              mem_addr <= pc_tag;
            end
          end
        end
        DEMAND: begin
          if (mem_ack) begin
            mem_req <= 1'b0;
            if (discard) begin
              state <= IDLE;
            end else begin
              // miss answers straight from the returning line to save a cycle
              idone  <= 1'b1;
              iready <= 1'b1;
              ins    <= mem_rdata[16*psel +: 16];
              state  <= RESP;
            end
          end
        end
        RESP: begin
          if (!idone) begin
            idone  <= 1'b1;
            iready <= 1'b1;
            ins    <= cur_data[16*psel +: 16];
          end
          if (nxt_valid) begin
            state <= IDLE;
          end else begin
            state    <= PREFETCH;
            mem_req  <= 1'b1;
            mem_addr <= TW'(cur_tag + 1'b1);
          end
        end
        PREFETCH: begin
          if (mem_ack) begin
            mem_req <= 1'b0;
            state   <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_prefetch.sv
// Directed bench for fetch_prefetch (RV=VA=32) with an expected-parcel scoreboard.
module tb_fetch_prefetch;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:1] pc;
  logic        ifetch, i_flush;
  logic [15:0] ins;
  logic        iready, idone, mem_req;
  logic [31:2] mem_addr;
  logic        mem_ack;
  logic [31:0] mem_rdata;

  int total = 0;
  int bad   = 0;
  logic [15:0] exp_q[$];

  fetch_prefetch #(.RV(32), .VA(32)) dut (
    .clk      (clk),
    .reset    (reset),
    .pc       (pc),
    .ifetch   (ifetch),
    .i_flush  (i_flush),
    .ins      (ins),
    .iready   (iready),
    .idone    (idone),
    .mem_req  (mem_req),
    .mem_addr (mem_addr),
    .mem_ack  (mem_ack),
    .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic fetch(input logic [31:1] a, input logic [15:0] e);
    pc     = a;
    ifetch = 1'b1;
    exp_q.push_back(e);
  endtask

  task automatic wait_req(input string tag, input logic [31:2] a);
    for (int i = 0; i < 20 && !mem_req; i++) tick();
    chk({tag, "_req"}, mem_req, 1);
    chk({tag, "_addr"}, mem_addr, a);
  endtask

  task automatic ack(input logic [31:0] d);
    mem_ack   = 1'b1;
    mem_rdata = d;
    tick();
    mem_ack   = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int max);
    logic [15:0] e;
    for (int i = 0; i < max && !idone; i++) tick();
    chk({tag, "_idone"}, idone, 1);
    chk({tag, "_iready"}, iready, 1);
    if (exp_q.size() == 0) begin
      chk({tag, "_sb_empty"}, 64'(exp_q.size()), 1);
    end else begin
      e = exp_q.pop_front();
      chk({tag, "_ins"}, ins, e);
    end
  endtask

  task automatic release_req(input string tag);
    tick();
    ifetch = 1'b0;
    chk({tag, "_pulse"}, idone, 0);
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    reset = 1'b1; pc = '0; ifetch = 1'b0; i_flush = 1'b0;
    mem_ack = 1'b0; mem_rdata = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ins", ins, 0);
    chk("rst_iready", iready, 0);
    chk("rst_idone", idone, 0);
    chk("rst_mem_req", mem_req, 0);
    reset = 1'b0;
    tick();

    // cold miss, answer one cycle after ack, then prefetch of line 1
    fetch(31'h0, 16'h1111);
    wait_req("c1_dem", 30'h0);
    ack(32'h2222_1111);
    wait_done("c1", 0);
    release_req("c1");
    wait_req("c1_pf", 30'h1);
    tick(); tick();
    chk("c1_pf_hold_req", mem_req, 1);
    chk("c1_pf_hold_addr", mem_addr, 30'h1);
    ack(32'h4444_3333);
    chk("c1_pf_drop", mem_req, 0);

    // hit in CUR: idone exactly two cycles after ifetch rises
    fetch(31'h1, 16'h2222);
    tick();
    chk("c2_early", idone, 0);
    chk("c2_iready_clr", iready, 0);
    tick();
    wait_done("c2", 0);
    chk("c2_nodemand", mem_req, 0);
    release_req("c2");
    chk("c2_nodemand2", mem_req, 0);

    // NXT promote, then prefetch of line 2
    fetch(31'h2, 16'h3333);
    tick();
    chk("c3_nodemand", mem_req, 0);
    tick();
    wait_done("c3", 0);
    wait_req("c3_pf", 30'h2);
    release_req("c3");

    // request while the prefetch is outstanding
    fetch(31'h40, 16'hAAAA);
    tick(); tick(); tick();
    chk("c4_wait", idone, 0);
    chk("c4_pf_addr", mem_addr, 30'h2);
    ack(32'h6666_5555);
    chk("c4_after_pf", idone, 0);
    wait_req("c4_dem", 30'h20);
    ack(32'hBBBB_AAAA);
    wait_done("c4", 0);
    release_req("c4");
    wait_req("c4_pf", 30'h21);
    ack(32'h8888_7777);
    tick();

    // flush during DEMAND: data dropped, same line refetched
    fetch(31'h103, 16'hDDDD);
    wait_req("c5_dem", 30'h81);
    i_flush = 1'b1;
    tick();
    i_flush = 1'b0;
    ack(32'hEEEE_FFFF);
    chk("c5_discard", idone, 0);
    wait_req("c5_refetch", 30'h81);
    ack(32'hDDDD_CCCC);
    wait_done("c5", 0);
    release_req("c5");
    wait_req("c5_pf", 30'h82);
    ack(32'h1212_3434);
    tick();

    // flush with a NXT hit in IDLE is a miss
    fetch(31'h104, 16'h7878);
    i_flush = 1'b1;
    tick();
    i_flush = 1'b0;
    wait_req("c5b_dem", 30'h82);
    ack(32'h5656_7878);
    wait_done("c5b", 0);
    release_req("c5b");
    wait_req("c5b_pf", 30'h83);
    ack(32'h0);
    tick();

    // last line wraps to line 0, then reset mid-prefetch
    fetch(31'h7FFF_FFFF, 16'h9999);
    wait_req("c6_dem", 30'h3FFF_FFFF);
    ack(32'h9999_0000);
    wait_done("c6", 0);
    release_req("c6");
    wait_req("c6_wrap", 30'h0);
    reset = 1'b1;
    #1;
    chk("c6_rst_req", mem_req, 0);
    chk("c6_rst_iready", iready, 0);
    tick();
    reset = 1'b0;
    ack(32'hFFFF_FFFF);
    chk("c6_late_req", mem_req, 0);
    chk("c6_late_idone", idone, 0);
    fetch(31'h7FFF_FFFF, 16'h1357);
    tick();
    chk("c6_inval_idone", idone, 0);
    wait_req("c6_refill", 30'h3FFF_FFFF);
    ack(32'h1357_2468);
    wait_done("c6r", 0);
    release_req("c6r");

    chk("sb_drained", 64'(exp_q.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
